// File: rtl/comparator_iterative_if.sv
// rtl/comparator_iterative_if.sv - operand/result handshake bundle for comparator_iterative
// Purpose: groups the operand and result handshake signals.
// master : producer of operands and consumer of results.
// slave  : the comparator.
// Signals: in_valid/in_ready, A, B, signed_mode (operand side).
//          out_valid/out_ready, equal, larger, smaller (result side).
interface comparator_iterative_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             equal;
    logic             larger;
    logic             smaller;

    modport master (
        output in_valid, A, B, signed_mode, out_ready,
        input  in_ready, out_valid, equal, larger, smaller
    );

    modport slave (
        input  in_valid, A, B, signed_mode, out_ready,
        output in_ready, out_valid, equal, larger, smaller
    );
endinterface

// File: rtl/comparator_iterative.sv
// rtl/comparator_iterative.sv - multi-cycle chunked magnitude comparator with early exit
// Purpose: compares A and B CHUNK bits per cycle, MSB chunk first. It stops at
//          the first chunk that differs. Signed and unsigned modes are supported.
// Ports: clk   - clock, rising edge
//        rst_n - asynchronous active-low reset
//        flush - synchronous abort of any operation in flight
//        bus   - operand/result handshake bundle (slave side)
module comparator_iterative #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    comparator_iterative_if.slave bus
);
    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("comparator_iterative: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]    IDX_TOP   = IW'(N - 1);
    localparam logic [CHUNK-1:0] SIGN_MASK = CHUNK'(1) << (CHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic             equal_q;
    logic             larger_q;
    logic             smaller_q;

    // The operand registers shift left after each equal chunk, so the chunk
    // under inspection is always the top CHUNK bits. Only the fixed top slice is read.
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             chunk_gt;
    logic             chunk_lt;

    always_comb begin
        a_chunk = a_q[WIDTH-1 -: CHUNK];
        b_chunk = b_q[WIDTH-1 -: CHUNK];
        // Inverting the sign bit of the top chunk maps two's-complement order
        // onto unsigned order. The lower chunks are plain magnitude bits.
        if (sgn_q && (idx_q == IDX_TOP)) begin
            a_chunk = a_chunk ^ SIGN_MASK;
            b_chunk = b_chunk ^ SIGN_MASK;
        end
        chunk_gt = (a_chunk > b_chunk);
        chunk_lt = (a_chunk < b_chunk);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            equal_q   <= 1'b0;
            larger_q  <= 1'b0;
            smaller_q <= 1'b0;
        end else if (flush) begin
            state_q   <= IDLE;
            equal_q   <= 1'b0;
            larger_q  <= 1'b0;
            smaller_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        sgn_q   <= bus.signed_mode;
                        idx_q   <= IDX_TOP;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (chunk_gt || chunk_lt) begin
                        larger_q  <= chunk_gt;
                        smaller_q <= chunk_lt;
                        state_q   <= DONE;
                    end else if (idx_q == '0) begin
                        equal_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                        a_q   <= a_q << CHUNK;
                        b_q   <= b_q << CHUNK;
                    end
                end
                DONE: begin
                    // Results are cleared on leaving DONE, so they read 0 whenever out_valid is 0.
                    if (bus.out_ready) begin
                        equal_q   <= 1'b0;
                        larger_q  <= 1'b0;
                        smaller_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The handshake outputs are decoded from the state only.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.equal     = equal_q;
    assign bus.larger    = larger_q;
    assign bus.smaller   = smaller_q;
endmodule

// File: tb/tb_comparator_iterative.sv
// tb/tb_comparator_iterative.sv - self-checking bench for comparator_iterative
module tb_comparator_iterative;
    localparam int WIDTH = 32;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic clk;
    logic rst_n;
    logic flush;

    int checks = 0;
    int errors = 0;

    comparator_iterative_if #(.WIDTH(WIDTH)) bus ();

    comparator_iterative #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
        logic        eq;
        logic        lg;
        logic        st;
        int          k;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts rising edges until out_valid is seen; k=0 means the bound expired.
    // scan_busy flags any in_ready=1 observed before the result arrives.
    task automatic wait_done(output int k, output logic scan_busy);
        k = 0;
        scan_busy = 1'b0;
        for (int i = 1; i <= N + 4; i++) begin
            if (k == 0) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.out_valid) k = i;
                else if (bus.in_ready) scan_busy = 1'b1;
            end
        end
    endtask

    // Presents an operand at a negedge. It returns just after the acceptance edge with in_valid dropped.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sm);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.signed_mode = sm;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int k;
        logic busy;
        start_op(v.a, v.b, v.sm);
        chk($sformatf("v%0d accepted", n), {31'd0, bus.in_ready}, 32'd0);
        wait_done(k, busy);
        chk($sformatf("v%0d latency", n), k, v.k);
        chk($sformatf("v%0d in_ready in scan", n), {31'd0, busy}, 32'd0);
        chk($sformatf("v%0d result eq/lg/sm", n),
            {29'd0, bus.equal, bus.larger, bus.smaller}, {29'd0, v.eq, v.lg, v.st});
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk($sformatf("v%0d back to idle", n),
            {28'd0, bus.in_ready, bus.out_valid, bus.equal | bus.larger, bus.smaller}, 32'h8);
    endtask

    initial begin
        int k;
        logic busy;
        logic saw_valid;

        vecs[0]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[1]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[3]  = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 8};
        vecs[4]  = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0, 8};
        vecs[5]  = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b1, 1'b0, 8};
        vecs[6]  = '{32'h0000_0050, 32'h0000_0030, 1'b0, 1'b0, 1'b1, 1'b0, 7};
        vecs[7]  = '{32'h0010_0000, 32'h0020_0000, 1'b0, 1'b0, 1'b0, 1'b1, 3};
        vecs[8]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b1, 1'b0, 8};
        vecs[9]  = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[11] = '{32'h1234_5678, 32'h1234_5679, 1'b0, 1'b0, 1'b0, 1'b1, 8};

        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.signed_mode = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset state", {27'd0, bus.in_ready, bus.out_valid, bus.equal, bus.larger, bus.smaller},
            32'h10);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Backpressure, then back-to-back acceptance with in_valid held high.
        start_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        wait_done(k, busy);
        chk("bp latency", k, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold %0d", i),
                {28'd0, bus.in_ready, bus.out_valid, bus.larger, bus.equal | bus.smaller}, 32'h6);
        end
        bus.A = 32'h0000_0001;
        bus.B = 32'h0000_0002;
        bus.signed_mode = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("b2b idle", {30'd0, bus.in_ready, bus.out_valid}, 32'h2);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("b2b accepted", {31'd0, bus.in_ready}, 32'd0);
        wait_done(k, busy);
        chk("b2b latency", k, 8);
        chk("b2b result", {29'd0, bus.equal, bus.larger, bus.smaller}, 32'h1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Flush on the third SCAN cycle of an equal compare.
        start_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush idle", {27'd0, bus.in_ready, bus.out_valid, bus.equal, bus.larger, bus.smaller},
            32'h10);
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1'b1;
        end
        chk("flush no out_valid", {31'd0, saw_valid}, 32'd0);

        // flush beats in_valid in IDLE.
        @(negedge clk);
        bus.A = 32'h1;
        bus.B = 32'h2;
        bus.in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        flush = 1'b0;
        chk("flush blocks accept", {31'd0, bus.in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("flush blocks accept later", {30'd0, bus.in_ready, bus.out_valid}, 32'h2);

        // Asynchronous reset mid-SCAN.
        start_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset in scan", {27'd0, bus.in_ready, bus.out_valid, bus.equal, bus.larger,
            bus.smaller}, 32'h10);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while DONE is holding a result.
        start_op(32'h0000_0000, 32'h0000_0001, 1'b0);
        wait_done(k, busy);
        chk("pre-reset done", {30'd0, bus.out_valid, bus.smaller}, 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset in done", {27'd0, bus.in_ready, bus.out_valid, bus.equal, bus.larger,
            bus.smaller}, 32'h10);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(100, vecs[7]);
        run_vec(101, vecs[4]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
